// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - encodes RV32I field requests into words and streams them into instruction memory
//
// Turns one field-level request at a time into a 32-bit RV32I instruction word and
// writes it to consecutive instruction-memory addresses. The program is closed with
// the HALT word (all ones).
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  request handshake; a transfer happens when both are high
//   req_fmt          0 R,1 I-ALU,2 LOAD,3 S,4 B,5 LUI,6 AUIPC,7 JAL,8 JALR,9 HALT
//   req_funct3/7     function fields (funct7 is also the upper immediate for I shifts)
//   req_rd/rs1/rs2   register fields
//   req_imm          immediate (byte offset; U-type uses bits 31:12)
//   req_last         final request; HALT follows it
//   iwen/iaddr/istore  memory write port, held until a cycle with iwait low
//   iwait            memory busy
//   done             program fully written, HALT included
//   err              sticky illegal-format / misaligned-offset / capacity error
//   word_count       words written so far, HALT included
module rv_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_fmt,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    input  logic        req_last,
    output logic        iwen,
    output logic [31:0] iaddr,
    output logic [31:0] istore,
    input  logic        iwait,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    localparam logic [3:0] FMT_R     = 4'd0;
    localparam logic [3:0] FMT_I     = 4'd1;
    localparam logic [3:0] FMT_LOAD  = 4'd2;
    localparam logic [3:0] FMT_S     = 4'd3;
    localparam logic [3:0] FMT_B     = 4'd4;
    localparam logic [3:0] FMT_LUI   = 4'd5;
    localparam logic [3:0] FMT_AUIPC = 4'd6;
    localparam logic [3:0] FMT_JAL   = 4'd7;
    localparam logic [3:0] FMT_JALR  = 4'd8;
    localparam logic [3:0] FMT_HALT  = 4'd9;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [15:0] LAST_DATA_SLOT = 16'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_HALT_WR = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] enc_word;
    logic        fmt_illegal;
    logic        imm_misaligned;
    logic        at_capacity;
    logic        last_q;
    logic        take_word;
    logic        take_halt;
    logic        set_err;
    logic        advance;

    // Field packing for every legal format.
    always_comb begin
        enc_word = 32'h0;
        unique case (req_fmt)
            FMT_R:     enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
            FMT_I: begin
                // Shifts carry funct7 above a 5-bit shift amount instead of a 12-bit immediate.
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101)
                    enc_word = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, 7'b0010011};
                else
                    enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
            end
            FMT_LOAD:  enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
            FMT_S:     enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'b0100011};
            FMT_B:     enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                                   req_imm[4:1], req_imm[11], 7'b1100011};
            FMT_LUI:   enc_word = {req_imm[31:12], req_rd, 7'b0110111};
            FMT_AUIPC: enc_word = {req_imm[31:12], req_rd, 7'b0010111};
            FMT_JAL:   enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                                   req_rd, 7'b1101111};
            FMT_JALR:  enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
            default:   enc_word = 32'h0;
        endcase
    end

    assign fmt_illegal    = (req_fmt > FMT_HALT);
    assign imm_misaligned = (req_fmt == FMT_B || req_fmt == FMT_JAL) && req_imm[0];
    // The final slot is kept free so HALT always fits.
    assign at_capacity    = (word_count == LAST_DATA_SLOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        take_word = 1'b0;
        take_halt = 1'b0;
        set_err   = 1'b0;
        advance   = 1'b0;
        req_ready = 1'b0;
        iwen      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fmt == FMT_HALT) begin
                        state_n   = S_HALT_WR;
                        take_halt = 1'b1;
                    end else if (fmt_illegal || imm_misaligned) begin
                        set_err = 1'b1;
                        if (req_last) begin
                            state_n   = S_HALT_WR;
                            take_halt = 1'b1;
                        end
                    end else if (at_capacity) begin
                        set_err   = 1'b1;
                        state_n   = S_HALT_WR;
                        take_halt = 1'b1;
                    end else begin
                        state_n   = S_WRITE;
                        take_word = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                iwen = 1'b1;
                if (!iwait) begin
                    advance = 1'b1;
                    if (last_q) begin
                        state_n   = S_HALT_WR;
                        take_halt = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_HALT_WR: begin
                iwen = 1'b1;
                if (!iwait) begin
                    advance = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iaddr      <= BASE_ADDR;
            istore     <= 32'h0;
            word_count <= 16'h0;
            err        <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (take_word) begin
                istore <= enc_word;
                last_q <= req_last;
            end
            if (take_halt) istore <= HALT_WORD;
            if (advance) begin
                iaddr      <= iaddr + 32'd4;
                word_count <= word_count + 16'd1;
            end
            if (set_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb/tb_rv_instr_encoder.sv - self-checking bench for rv_instr_encoder
module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        req_valid;
    logic [3:0]  req_fmt;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        req_last;
    logic        iwait;

    logic        ready_a, iwen_a, done_a, err_a;
    logic [31:0] iaddr_a, istore_a;
    logic [15:0] wc_a;
    logic        ready_b, iwen_b, done_b, err_b;
    logic [31:0] iaddr_b, istore_b;
    logic [15:0] wc_b;

    logic        sel;
    logic        o_ready, o_iwen, o_done, o_err;
    logic [31:0] o_iaddr, o_istore;
    logic [15:0] o_wc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_instr_encoder #(.BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid), .req_ready(ready_a),
        .req_fmt(req_fmt), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_last(req_last), .iwen(iwen_a), .iaddr(iaddr_a), .istore(istore_a),
        .iwait(iwait), .done(done_a), .err(err_a), .word_count(wc_a)
    );

    rv_instr_encoder #(.BASE_ADDR(32'h0), .MAX_WORDS(4)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_ready(ready_b),
        .req_fmt(req_fmt), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_last(req_last), .iwen(iwen_b), .iaddr(iaddr_b), .istore(istore_b),
        .iwait(iwait), .done(done_b), .err(err_b), .word_count(wc_b)
    );

    assign o_ready  = sel ? ready_b  : ready_a;
    assign o_iwen   = sel ? iwen_b   : iwen_a;
    assign o_done   = sel ? done_b   : done_a;
    assign o_err    = sel ? err_b    : err_a;
    assign o_iaddr  = sel ? iaddr_b  : iaddr_a;
    assign o_istore = sel ? istore_b : istore_a;
    assign o_wc     = sel ? wc_b     : wc_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: each field is placed by shifting its numeric value to its bit position.
    function automatic logic [31:0] ref_enc(input int fmt, input int f3, input int f7, input int rd,
                                            input int rs1, input int rs2, input logic [31:0] imm);
        int unsigned u;
        int unsigned w;
        u = imm;
        case (fmt)
            0: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
            1: if (f3 == 1 || f3 == 5)
                   w = (f7 << 25) + ((u % 32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
               else
                   w = ((u % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
            2: w = ((u % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h03;
            3: w = (((u >> 5) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                   + ((u % 32) << 7) + 'h23;
            4: w = (((u >> 12) % 2) << 31) + (((u >> 5) % 64) << 25) + (rs2 << 20) + (rs1 << 15)
                   + (f3 << 12) + (((u >> 1) % 16) << 8) + (((u >> 11) % 2) << 7) + 'h63;
            5: w = ((u >> 12) << 12) + (rd << 7) + 'h37;
            6: w = ((u >> 12) << 12) + (rd << 7) + 'h17;
            7: w = (((u >> 20) % 2) << 31) + (((u >> 1) % 1024) << 21) + (((u >> 11) % 2) << 20)
                   + (((u >> 12) % 256) << 12) + (rd << 7) + 'h6F;
            8: w = ((u % 4096) << 20) + (rs1 << 15) + (rd << 7) + 'h67;
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic issue(input int fmt, input int f3, input int f7, input int rd, input int rs1,
                         input int rs2, input logic [31:0] imm, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("issue_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_fmt    = 4'(fmt);
        req_funct3 = 3'(f3);
        req_funct7 = 7'(f7);
        req_rd     = 5'(rd);
        req_rs1    = 5'(rs1);
        req_rs2    = 5'(rs2);
        req_imm    = imm;
        req_last   = last;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    // Waits for the completing write cycle, optionally with random memory stalls.
    task automatic do_write(input string tag, input logic [31:0] exp_w, input logic [31:0] exp_a,
                            input bit rnd, output int lat);
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            iwait = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (o_iwen && !iwait) begin
                lat = c;
                chk({tag, "_data"}, o_istore, exp_w);
                chk({tag, "_addr"}, o_iaddr, exp_a);
                @(posedge clk);
                #1;
                iwait = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        iwait = 1'b0;
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    initial begin
        int lat;
        int fmt, f3, f7, rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_w;

        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        req_valid = 1'b0; req_fmt = '0; req_funct3 = '0; req_funct7 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_last = 1'b0; iwait = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_iwen", 32'(o_iwen), 32'd0);
        chk("rst_iaddr", o_iaddr, 32'h0);
        chk("rst_istore", o_istore, 32'h0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_wc", 32'(o_wc), 32'd0);
        rst_a = 1'b0;

        // R ADD, minimum latency
        issue(0, 0, 0, 3, 1, 2, 32'h0, 1'b0);
        do_write("add", 32'h002081B3, 32'h0, 1'b0, lat);
        chk("add_latency", 32'(lat), 32'd0);
        chk("add_iwen_drop", 32'(o_iwen), 32'd0);
        chk("add_wc", 32'(o_wc), 32'd1);
        chk("add_iaddr_next", o_iaddr, 32'h4);

        // ADDI then SW
        reset_a();
        issue(1, 0, 0, 1, 0, 0, 32'd5, 1'b0);
        do_write("addi", 32'h00500093, 32'h0, 1'b0, lat);
        issue(3, 2, 0, 0, 1, 2, 32'd8, 1'b0);
        do_write("sw", 32'h0020A423, 32'h4, 1'b0, lat);

        // BEQ -4 as last request, then HALT
        reset_a();
        issue(4, 0, 0, 0, 1, 2, 32'hFFFF_FFFC, 1'b1);
        do_write("beq", 32'hFE208EE3, 32'h0, 1'b0, lat);
        do_write("beq_halt", 32'hFFFF_FFFF, 32'h4, 1'b0, lat);
        @(negedge clk);
        chk("beq_done", 32'(o_done), 32'd1);
        chk("beq_wc", 32'(o_wc), 32'd2);
        chk("beq_ready", 32'(o_ready), 32'd0);

        // LUI with memory busy for 3 cycles
        reset_a();
        iwait = 1'b1;
        issue(5, 0, 0, 5, 0, 0, 32'h1234_5000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lui_hold_iwen", 32'(o_iwen), 32'd1);
            chk("lui_hold_data", o_istore, 32'h123452B7);
            chk("lui_hold_ready", 32'(o_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        do_write("lui", 32'h123452B7, 32'h0, 1'b0, lat);
        chk("lui_wc", 32'(o_wc), 32'd1);

        // Misaligned JAL: error, nothing written
        reset_a();
        issue(7, 0, 0, 1, 0, 0, 32'h3, 1'b0);
        @(negedge clk);
        chk("jal_err", 32'(o_err), 32'd1);
        chk("jal_iwen", 32'(o_iwen), 32'd0);
        chk("jal_wc", 32'(o_wc), 32'd0);
        chk("jal_ready", 32'(o_ready), 32'd1);

        // Illegal format with last: error, only HALT written
        reset_a();
        issue(12, 0, 0, 0, 0, 0, 32'h0, 1'b1);
        do_write("illegal_halt", 32'hFFFF_FFFF, 32'h0, 1'b0, lat);
        @(negedge clk);
        chk("illegal_err", 32'(o_err), 32'd1);
        chk("illegal_wc", 32'(o_wc), 32'd1);
        chk("illegal_done", 32'(o_done), 32'd1);

        // Random legal program with random stalls
        reset_a();
        for (int i = 0; i < 24; i++) begin
            fmt = $urandom_range(0, 8);
            f3  = $urandom_range(0, 7);
            f7  = $urandom_range(0, 127);
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = $urandom;
            if (fmt == 4 || fmt == 7) imm[0] = 1'b0;
            exp_w = ref_enc(fmt, f3, f7, rd, rs1, rs2, imm);
            issue(fmt, f3, f7, rd, rs1, rs2, imm, i == 23);
            do_write("rand", exp_w, 32'(4 * i), 1'b1, lat);
        end
        do_write("rand_halt", 32'hFFFF_FFFF, 32'(4 * 24), 1'b1, lat);
        @(negedge clk);
        chk("rand_done", 32'(o_done), 32'd1);
        chk("rand_wc", 32'(o_wc), 32'd25);
        chk("rand_err", 32'(o_err), 32'd0);

        // Capacity overflow on the 4-word instance
        @(negedge clk);
        rst_a = 1'b1;
        sel = 1'b1;
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 0, i + 1, 0, 0, 32'(i), 1'b0);
            do_write("cap", ref_enc(1, 0, 0, i + 1, 0, 0, 32'(i)), 32'(4 * i), 1'b0, lat);
        end
        issue(1, 0, 0, 4, 0, 0, 32'd3, 1'b0);
        do_write("cap_halt", 32'hFFFF_FFFF, 32'hC, 1'b0, lat);
        @(negedge clk);
        chk("cap_err", 32'(o_err), 32'd1);
        chk("cap_done", 32'(o_done), 32'd1);
        chk("cap_wc", 32'(o_wc), 32'd4);

        // Reset in the middle of a write
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        issue(1, 0, 0, 1, 0, 0, 32'd7, 1'b0);
        @(negedge clk);
        chk("midrst_iwen_before", 32'(o_iwen), 32'd1);
        rst_b = 1'b1;
        #1;
        chk("midrst_iwen", 32'(o_iwen), 32'd0);
        chk("midrst_wc", 32'(o_wc), 32'd0);
        chk("midrst_iaddr", o_iaddr, 32'h0);
        chk("midrst_istore", o_istore, 32'h0);
        @(negedge clk);
        rst_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
